// File: rtl/puf_challenge_sequencer.sv
// Serial PUF challenge sequencer: latches each scrambled challenge, runs one RO
// measurement window per challenge and assembles a RESP_BITS-wide response word.
module puf_challenge_sequencer #(
    parameter int RESP_BITS = 16,
    parameter int WINDOW    = 1024,
    parameter int SETTLE    = 2,
    parameter int CNT_W     = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [7:0]           chall_in,
    input  logic [CNT_W-1:0]     cnt_a,
    input  logic [CNT_W-1:0]     cnt_b,
    output logic                 increment,
    output logic [7:0]           challenge_q,
    output logic                 ro_clear,
    output logic                 ro_enable,
    output logic [RESP_BITS-1:0] response,
    output logic                 resp_valid,
    output logic                 busy
);

    localparam int IDX_W = $clog2(RESP_BITS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_CLEAR,
        S_MEASURE,
        S_SETTLE,
        S_COMPARE,
        S_ADVANCE,
        S_DONE
    } state_t;

    state_t                 state;
    state_t                 state_n;
    logic [15:0]            win_cnt;
    logic [3:0]             set_cnt;
    logic [IDX_W-1:0]       idx;
    logic [RESP_BITS-1:0]   shreg;
    logic [RESP_BITS-1:0]   word_n;
    logic                   win_last;
    logic                   set_last;
    logic                   idx_last;
    logic                   bit_now;
    logic                   busy_d;
    logic                   ro_enable_d;
    logic                   ro_clear_d;
    logic                   increment_d;
    logic                   resp_valid_d;

    assign win_last = (win_cnt == 16'(WINDOW - 1));
    assign set_last = (set_cnt == 4'(SETTLE - 1));
    assign idx_last = (idx == IDX_W'(RESP_BITS - 1));
    assign bit_now  = (cnt_a > cnt_b);

    // Response word with the current compare result folded in, so DONE can
    // present the final bit without an extra cycle.
    always_comb begin
        word_n      = shreg;
        word_n[idx] = bit_now;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:    if (start) state_n = S_LATCH;
            S_LATCH:   state_n = S_CLEAR;
            S_CLEAR:   state_n = S_MEASURE;
            S_MEASURE: if (win_last) state_n = S_SETTLE;
            S_SETTLE:  if (set_last) state_n = S_COMPARE;
            S_COMPARE: state_n = idx_last ? S_DONE : S_ADVANCE;
            S_ADVANCE: state_n = S_LATCH;
            S_DONE:    state_n = S_IDLE;
            default:   state_n = S_IDLE;
        endcase
        // Abort wins everywhere, including over start while idle.
        if (abort) state_n = S_IDLE;

        busy_d       = (state_n != S_IDLE);
        ro_enable_d  = (state_n == S_MEASURE);
        ro_clear_d   = (state_n == S_CLEAR);
        increment_d  = (state_n == S_ADVANCE);
        resp_valid_d = (state_n == S_DONE);
    end

    // Outputs are registered from the next state so they line up with the state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            ro_enable  <= 1'b0;
            ro_clear   <= 1'b0;
            increment  <= 1'b0;
            resp_valid <= 1'b0;
        end else begin
            state      <= state_n;
            busy       <= busy_d;
            ro_enable  <= ro_enable_d;
            ro_clear   <= ro_clear_d;
            increment  <= increment_d;
            resp_valid <= resp_valid_d;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            win_cnt     <= '0;
            set_cnt     <= '0;
            idx         <= '0;
            shreg       <= '0;
            challenge_q <= '0;
            response    <= '0;
        end else begin
            if (state == S_IDLE && state_n == S_LATCH) begin
                idx   <= '0;
                shreg <= '0;
            end
            if (state == S_LATCH)
                challenge_q <= chall_in;
            if (state == S_MEASURE)
                win_cnt <= win_cnt + 16'd1;
            else
                win_cnt <= '0;
            if (state == S_SETTLE)
                set_cnt <= set_cnt + 4'd1;
            else
                set_cnt <= '0;
            if (state == S_COMPARE)
                shreg <= word_n;
            if (state == S_ADVANCE && !abort)
                idx <= idx + 1'b1;
            if (state_n == S_DONE)
                response <= word_n;
        end
    end

endmodule
